// File: rtl/if_id_buffer.sv
// if_id_buffer: fetch-to-decode pipeline register with stall hold, flush bubbles and,
// when IFID_INT_EN is defined, an interrupt sequencer that injects INT_INSTR into decode.
module if_id_buffer #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
  parameter logic [31:0] INT_INSTR = 32'hF800_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instruction_in,
  input  logic [31:0] pc_in,
  input  logic        stall,
  input  logic        flush,
  input  logic        int_req,
  output logic [31:0] instruction_out,
  output logic [31:0] pc_out,
  output logic        valid_out,
  output logic        int_pending,
  output logic        int_taken
);
  logic [31:0] instr_q;
  logic [31:0] pc_q;
  logic        valid_q;
  assign instruction_out = instr_q;
  assign pc_out          = pc_q;
  assign valid_out       = valid_q;
`ifdef IFID_INT_EN
  typedef enum logic {IDLE, PENDING} state_t;
  state_t state_q;
  logic   int_req_q;
  logic   taken_q;
  logic   rise;
  logic   inject;
  assign rise        = int_req & ~int_req_q;
  assign inject      = (state_q == PENDING) & ~stall & ~flush;
  assign int_pending = state_q == PENDING;
  assign int_taken   = taken_q;
  // Pipeline register plus interrupt sequencer; a latched interrupt survives stalls and flushes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q   <= NOP_INSTR;
      pc_q      <= '0;
      valid_q   <= 1'b0;
      taken_q   <= 1'b0;
      state_q   <= IDLE;
      int_req_q <= 1'b0;
    end else begin
      int_req_q <= int_req;
      if (flush) begin
        instr_q <= NOP_INSTR;
        pc_q    <= '0;
        valid_q <= 1'b0;
        taken_q <= 1'b0;
      end else if (!stall) begin
        instr_q <= inject ? INT_INSTR : instruction_in;
        pc_q    <= pc_in;
        valid_q <= 1'b1;
        taken_q <= inject;
      end
      if (state_q == IDLE && rise) state_q <= PENDING;
      else if (inject) state_q <= IDLE;
    end
  end
`else
  logic unused_int_req;
  assign unused_int_req = int_req;
  assign int_pending    = 1'b0;
  assign int_taken      = 1'b0;
  // Plain pipeline register: flush squashes to a bubble, stall holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q <= NOP_INSTR;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else if (flush) begin
      instr_q <= NOP_INSTR;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else if (!stall) begin
      instr_q <= instruction_in;
      pc_q    <= pc_in;
      valid_q <= 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_if_id_buffer.sv
// tb_if_id_buffer: scoreboard bench for if_id_buffer; expectations adapt to IFID_INT_EN.
module tb_if_id_buffer;
  localparam logic [31:0] NOP = 32'h0000_0000;
  localparam logic [31:0] INT = 32'hF800_0000;
`ifdef IFID_INT_EN
  localparam bit IE = 1'b1;
`else
  localparam bit IE = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instruction_in = '0;
  logic [31:0] pc_in = '0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        int_req = 1'b0;
  logic [31:0] instruction_out;
  logic [31:0] pc_out;
  logic        valid_out;
  logic        int_pending;
  logic        int_taken;
  typedef struct {
    logic [31:0] i;
    logic [31:0] p;
    logic        v;
    logic        pd;
    logic        t;
    int          id;
  } exp_t;
  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   sid = 0;
  event ev_chk;

  if_id_buffer dut (
    .clk(clk), .rst(rst), .instruction_in(instruction_in), .pc_in(pc_in),
    .stall(stall), .flush(flush), .int_req(int_req),
    .instruction_out(instruction_out), .pc_out(pc_out), .valid_out(valid_out),
    .int_pending(int_pending), .int_taken(int_taken)
  );

  always #5 clk = ~clk;

  task automatic push(input logic [31:0] ei, input logic [31:0] ep, input logic ev,
                      input logic epd, input logic et);
    exp_t e;
    e.i = ei; e.p = ep; e.v = ev; e.pd = epd; e.t = et; e.id = sid;
    q.push_back(e);
    sid++;
  endtask

  task automatic step(input logic r, input logic s, input logic f, input logic ir,
                      input logic [31:0] ii, input logic [31:0] pi,
                      input logic [31:0] ei, input logic [31:0] ep, input logic ev,
                      input logic epd, input logic et);
    @(negedge clk);
    rst = r; stall = s; flush = f; int_req = ir; instruction_in = ii; pc_in = pi;
    push(ei, ep, ev, epd, et);
    @(posedge clk);
  endtask

  task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL step%0d %s: got %h expected %h", id, nm, act, req);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk or ev_chk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("instruction_out", e.id, instruction_out, e.i);
        chk("pc_out", e.id, pc_out, e.p);
        chk("valid_out", e.id, {31'b0, valid_out}, {31'b0, e.v});
        chk("int_pending", e.id, {31'b0, int_pending}, {31'b0, e.pd});
        chk("int_taken", e.id, {31'b0, int_taken}, {31'b0, e.t});
      end
    end
  end

  initial begin
    // reset held
    step(1, 0, 0, 0, 32'h1234_5678, 32'h4, NOP, 0, 0, 0, 0);
    step(1, 0, 0, 0, 32'h1234_5678, 32'h4, NOP, 0, 0, 0, 0);
    // streaming
    step(0, 0, 0, 0, 32'h1111_0001, 32'h5, 32'h1111_0001, 32'h5, 1, 0, 0);
    step(0, 0, 0, 0, 32'hA5A5_0000, 32'h8, 32'hA5A5_0000, 32'h8, 1, 0, 0);
    // stall hold with changing inputs
    for (int k = 0; k < 3; k++)
      step(0, 1, 0, 0, 32'hDEAD_0000 + k, 32'hC + k, 32'hA5A5_0000, 32'h8, 1, 0, 0);
    // flush over stall
    step(0, 1, 1, 0, 32'hBEEF_0000, 32'h10, NOP, 0, 0, 0, 0);
    step(0, 0, 0, 0, 32'h2222_0002, 32'hC, 32'h2222_0002, 32'hC, 1, 0, 0);
    // interrupt basic: edge N then inject at N+1
    step(0, 0, 0, 1, 32'h3333_0003, 32'h10, 32'h3333_0003, 32'h10, 1, IE, 0);
    step(0, 0, 0, 1, 32'h4444_0004, 32'h20, IE ? INT : 32'h4444_0004, 32'h20, 1, 0, IE);
    step(0, 0, 0, 1, 32'h5555_0005, 32'h24, 32'h5555_0005, 32'h24, 1, 0, 0);
    // interrupt delayed by two stalls and a flush, second edge ignored
    step(0, 0, 0, 0, 32'h6666_0006, 32'h28, 32'h6666_0006, 32'h28, 1, 0, 0);
    step(0, 0, 0, 1, 32'h7777_0007, 32'h2C, 32'h7777_0007, 32'h2C, 1, IE, 0);
    step(0, 1, 0, 0, 32'h7777_1111, 32'h30, 32'h7777_0007, 32'h2C, 1, IE, 0);
    step(0, 1, 0, 1, 32'h7777_2222, 32'h34, 32'h7777_0007, 32'h2C, 1, IE, 0);
    step(0, 0, 1, 1, 32'h7777_3333, 32'h38, NOP, 0, 0, IE, 0);
    step(0, 0, 0, 1, 32'h8888_0008, 32'h40, IE ? INT : 32'h8888_0008, 32'h40, 1, 0, IE);
    // stall right after inject keeps int_taken high
    step(0, 1, 0, 1, 32'h8888_1111, 32'h44, IE ? INT : 32'h8888_0008, 32'h40, 1, 0, IE);
    step(0, 0, 0, 1, 32'h9999_0009, 32'h44, 32'h9999_0009, 32'h44, 1, 0, 0);
    step(0, 0, 0, 0, 32'hAAAA_000A, 32'h48, 32'hAAAA_000A, 32'h48, 1, 0, 0);
    // async reset while pending
    step(0, 0, 0, 1, 32'hBBBB_000B, 32'h4C, 32'hBBBB_000B, 32'h4C, 1, IE, 0);
    @(negedge clk);
    #2;
    push(NOP, 0, 0, 0, 0);
    rst = 1'b1;
    int_req = 1'b0;
    -> ev_chk;
    @(posedge clk);
    step(1, 0, 0, 0, 32'hCCCC_0000, 32'h50, NOP, 0, 0, 0, 0);
    step(0, 0, 0, 0, 32'hCCCC_000C, 32'h50, 32'hCCCC_000C, 32'h50, 1, 0, 0);
    step(0, 0, 0, 0, 32'hDDDD_000D, 32'h54, 32'hDDDD_000D, 32'h54, 1, 0, 0);
    for (int k = 0; k < 20 && q.size() > 0; k++) @(posedge clk);
    #2;
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
